// File: rtl/lc3_dmem_responder.sv
// Data-memory responder for the PUnC core: valid/ready request and response channels,
// programmable wait states, flop-based word store and out-of-range error flagging.
module lc3_dmem_responder #(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           we_q, we_d;
    logic [15:0]    addr_q, addr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [15:0]    rsp_rdata_q, rsp_rdata_d;
    logic           rsp_err_q, rsp_err_d;
    logic [15:0]    mem_q [DEPTH];

    logic           do_work;
    logic           mem_we;
    logic           op_we;
    logic [15:0]    op_addr;
    logic [15:0]    op_wdata;
    logic           op_in_range;

    // With zero wait states the access happens on the accept edge, so use the live request.
    always_comb begin
        op_we    = we_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            op_we    = req_we;
            op_addr  = req_addr;
            op_wdata = req_wdata;
        end
        op_in_range = (32'(op_addr) < DEPTH);
    end

    // Next-state, capture and response computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        do_work     = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                        do_work = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CW'(LATENCY);
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_RESP;
                    do_work = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 16'h0000;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_work) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 16'h0000;
            rsp_err_d   = 1'b0;
            if (!op_in_range) begin
                rsp_err_d = 1'b1;
            end else if (op_we) begin
                mem_we = 1'b1;
            end else begin
                rsp_rdata_d = mem_q[op_addr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Word store; reset clears every location.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (mem_we) begin
            mem_q[op_addr[AW-1:0]] <= op_wdata;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Bench for lc3_dmem_responder: a LATENCY=2 and a LATENCY=0 instance checked every cycle
// against a transaction-level memory model, plus hand-computed directed expectations.
module tb_lc3_dmem_responder;

    localparam int unsigned DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [1:0]  rsp_ready;
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    wire  [1:0]  req_ready;
    wire  [1:0]  rsp_valid;
    wire  [1:0]  rsp_err;
    wire  [1:0]  busy;
    wire  [15:0] rsp_rdata [2];

    int nchk  = 0;
    int npass = 0;

    lc3_dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    lc3_dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            npass++;
    endtask

    // Transaction model: an access completes LATENCY edges after its accept edge,
    // then the response is presented until the requester takes it.
    int          ecount = 0;
    bit          pend [2];
    bit          inr  [2];
    int          acc_e [2];
    logic        m_we [2];
    logic [15:0] m_addr [2];
    logic [15:0] m_wd [2];
    logic [15:0] e_rd [2];
    logic        e_err [2];
    logic [15:0] mm [2][DEPTH];

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic void model_access(input int k);
        e_rd[k]  = 16'h0000;
        e_err[k] = 1'b0;
        if (int'(m_addr[k]) >= int'(DEPTH)) e_err[k] = 1'b1;
        else if (m_we[k]) mm[k][m_addr[k]] = m_wd[k];
        else e_rd[k] = mm[k][m_addr[k]];
        inr[k]  = 1'b1;
        pend[k] = 1'b0;
    endfunction

    always @(posedge clk) begin
        ecount++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                pend[k] = 0; inr[k] = 0; e_rd[k] = 16'h0000; e_err[k] = 1'b0;
                for (int i = 0; i < int'(DEPTH); i++) mm[k][i] = 16'h0000;
            end else if (inr[k]) begin
                if (rsp_ready[k]) begin
                    inr[k] = 0; e_rd[k] = 16'h0000; e_err[k] = 1'b0;
                end
            end else if (pend[k]) begin
                if (ecount == acc_e[k] + lat_of(k)) model_access(k);
            end else if (req_valid[k]) begin
                acc_e[k] = ecount; m_we[k] = req_we[k]; m_addr[k] = req_addr[k]; m_wd[k] = req_wdata[k];
                if (lat_of(k) == 0) model_access(k);
                else pend[k] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (ecount > 0) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("req_ready[%0d]", k), 32'(req_ready[k]), 32'(!pend[k] && !inr[k]));
                chk($sformatf("busy[%0d]", k),      32'(busy[k]),      32'(pend[k] || inr[k]));
                chk($sformatf("rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'(inr[k]));
                chk($sformatf("rsp_rdata[%0d]", k), 32'(rsp_rdata[k]), 32'(e_rd[k]));
                chk($sformatf("rsp_err[%0d]", k),   32'(rsp_err[k]),   32'(e_err[k]));
            end
        end
    end

    // Issue one request on instance k; starts and ends just after a falling edge.
    task automatic txn(input int k, input logic we, input logic [15:0] a, input logic [15:0] wd,
                       input int stall, output logic [15:0] rd, output logic er,
                       output int acc, output int vld);
        int n;
        logic [15:0] rd0;
        rd = 16'h0000; er = 1'b0; acc = 0; vld = 0;
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a; req_wdata[k] = wd;
        rsp_ready[k] = (stall == 0);
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            nchk++; $display("FAIL accept_timeout inst %0d: req_ready never 1", k);
            req_valid[k] = 1'b0; return;
        end
        @(posedge clk); #1;
        acc = ecount;
        req_valid[k] = 1'b0; req_we[k] = ~we; req_addr[k] = ~a; req_wdata[k] = ~wd;
        @(negedge clk);
        n = 0;
        while (rsp_valid[k] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            nchk++; $display("FAIL rsp_timeout inst %0d: rsp_valid never 1", k);
            rsp_ready[k] = 1'b1; @(negedge clk); rsp_ready[k] = 1'b0; return;
        end
        vld = ecount; rd = rsp_rdata[k]; er = rsp_err[k];
        rd0 = rd;
        chk("ready_low_in_resp", 32'(req_ready[k]), 32'd0);
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", 32'(rsp_valid[k]), 32'd1);
            chk("stall_rdata", 32'(rsp_rdata[k]), 32'(rd0));
            chk("stall_ready", 32'(req_ready[k]), 32'd0);
            req_valid[k] = 1'b1; req_we[k] = 1'b0; req_addr[k] = 16'd9;
            @(negedge clk);
        end
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[k] = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        logic er;
        int a0, v0, a1, v1;
        req_valid = '0; req_we = '0; rsp_ready = '0;
        for (int k = 0; k < 2; k++) begin req_addr[k] = '0; req_wdata[k] = '0; end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", 32'(req_ready[0]), 32'd1);
        chk("reset_valid", 32'(rsp_valid[0]), 32'd0);
        chk("reset_busy",  32'(busy[0]),      32'd0);

        txn(0, 1'b0, 16'h0005, 16'h0000, 0, rd, er, a0, v0);
        chk("read5_data", 32'(rd), 32'h0000);
        chk("read5_err",  32'(er), 32'd0);
        chk("lat2_delay", 32'(v0 - a0), 32'd2);

        txn(0, 1'b1, 16'h0010, 16'hBEEF, 0, rd, er, a0, v0);
        txn(0, 1'b0, 16'h0010, 16'h0000, 0, rd, er, a1, v1);
        chk("readback_beef", 32'(rd), 32'hBEEF);
        chk("lat2_spacing",  32'(a1 - a0), 32'd4);

        txn(0, 1'b0, 16'h3000, 16'h0000, 0, rd, er, a0, v0);
        chk("oor_read_err",  32'(er), 32'd1);
        chk("oor_read_data", 32'(rd), 32'h0000);
        txn(0, 1'b1, 16'h0080, 16'h1234, 0, rd, er, a0, v0);
        chk("oor_write_err", 32'(er), 32'd1);
        txn(0, 1'b0, 16'h0000, 16'h0000, 0, rd, er, a0, v0);
        chk("addr0_data", 32'(rd), 32'h0000);
        chk("addr0_err",  32'(er), 32'd0);
        txn(0, 1'b0, 16'h0090, 16'h0000, 0, rd, er, a0, v0);
        chk("no_alias_err",  32'(er), 32'd1);
        chk("no_alias_data", 32'(rd), 32'h0000);
        txn(0, 1'b1, 16'h007F, 16'h7F7F, 0, rd, er, a0, v0);
        txn(0, 1'b0, 16'h007F, 16'h0000, 0, rd, er, a0, v0);
        chk("top_addr_data", 32'(rd), 32'h7F7F);
        chk("top_addr_err",  32'(er), 32'd0);

        txn(0, 1'b1, 16'h0007, 16'h00AA, 0, rd, er, a0, v0);
        txn(0, 1'b0, 16'h0007, 16'h0000, 5, rd, er, a0, v0);
        chk("stall_read_data", 32'(rd), 32'h00AA);
        txn(0, 1'b0, 16'h0009, 16'h0000, 0, rd, er, a0, v0);
        chk("addr9_untouched", 32'(rd), 32'h0000);

        txn(1, 1'b0, 16'h0005, 16'h0000, 0, rd, er, a0, v0);
        chk("lat0_delay", 32'(v0 - a0), 32'd0);
        txn(1, 1'b1, 16'h0020, 16'h0C0D, 0, rd, er, a0, v0);
        txn(1, 1'b0, 16'h0020, 16'h0000, 0, rd, er, a0, v0);
        chk("lat0_readback", 32'(rd), 32'h0C0D);
        txn(1, 1'b0, 16'h0020, 16'h0000, 0, rd, er, a1, v1);
        chk("lat0_spacing", 32'(a1 - a0), 32'd2);

        // Reset lands while the write is still counting wait states.
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h0003; req_wdata[0] = 16'h5555;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 32'(req_ready[0]), 32'd1);
        chk("midrst_busy",  32'(busy[0]),      32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_valid", 32'(rsp_valid[0]), 32'd0);
            @(negedge clk);
        end
        txn(0, 1'b0, 16'h0003, 16'h0000, 0, rd, er, a0, v0);
        chk("midrst_read3", 32'(rd), 32'h0000);
        txn(0, 1'b0, 16'h0010, 16'h0000, 0, rd, er, a0, v0);
        chk("midrst_mem_cleared", 32'(rd), 32'h0000);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
